// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor. The master issues start
// and operands; the slave reports busy/done, the held result and its state.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    // start is accepted on a rising edge only while busy is low (IDLE or DONE);
    // a, b and b_in are captured on that same edge. done is a one-cycle pulse,
    // and d/b_out/v stay valid from it until the next done.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             v;
    logic [1:0]       dbg_state;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out, v, dbg_state
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out, v, dbg_state
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - b_in, one bit per clock,
// LSB first, framed by a start/done handshake with the result held between ops.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               b_out_q, b_out_d;
    logic               v_q, v_d;

    logic               diff_bit;
    logic               borrow_nx;
    logic [WIDTH-1:0]   res_nx;

    // One full-subtractor cell, reused every cycle on the operand LSBs.
    assign diff_bit  = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    assign borrow_nx = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
    assign res_nx    = {diff_bit, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        d_d      = d_q;
        b_out_d  = b_out_q;
        v_d      = v_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d  = RUN;
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    borrow_d = bus.b_in;
                    cnt_d    = '0;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                end
            end
            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_nx;
                borrow_d = borrow_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    d_d     = res_nx;
                    b_out_d = borrow_nx;
                    // Overflow only when operand signs differ and the result
                    // sign departs from the minuend's.
                    v_d     = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_bit);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= '0;
            b_out_q  <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            d_q      <= d_d;
            b_out_q  <= b_out_d;
            v_q      <= v_d;
        end
    end

    // busy/done decode straight from the state flop, so they carry no comb logic from inputs.
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.d         = d_q;
    assign bus.b_out     = b_out_q;
    assign bus.v         = v_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: driver pushes hand-computed results,
// a negedge monitor pops them on every done pulse and checks value and latency.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   done_seen;

  logic [W+1:0] exp_q[$];   // {d, b_out, v}
  int           cyc_q[$];   // cycle count at which done must be seen

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, " done"}, {31'd0, bus.done}, 32'd0);
    check({name, " d"}, {28'd0, bus.d}, 32'd0);
    check({name, " b_out"}, {31'd0, bus.b_out}, 32'd0);
    check({name, " v"}, {31'd0, bus.v}, 32'd0);
  endtask

  // driver tasks (called at a negedge)
  task automatic wait_ready();
    int k = 0;
    while (bus.busy === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("wait_ready timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W+1:0] exp, input bit hold);
    wait_ready();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + W + 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("result {d,b_out,v}", {26'd0, bus.d, bus.b_out, bus.v}, {26'd0, e});
        check("done latency", cyc, ec);
      end
    end
  end

  initial begin
    int k;
    int done_before;
    n_cmp = 0;
    n_err = 0;
    done_seen = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.b_in = 1'b0;
    idle_cycles(3);
    check_outputs_zero("reset");
    check("reset state", {30'd0, bus.dbg_state}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // 5 - 3 with busy profile
    issue(4'b0101, 4'b0011, 1'b0, {4'b0010, 1'b0, 1'b0}, 1'b0);
    for (int i = 1; i <= W; i++) begin
      check($sformatf("busy cycle %0d", i), {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
    check("busy in DONE", {31'd0, bus.busy}, 32'd0);
    check("done pulse", {31'd0, bus.done}, 32'd1);
    idle_cycles(3);
    check("d held in IDLE", {28'd0, bus.d}, 32'h2);
    check("done low in IDLE", {31'd0, bus.done}, 32'd0);

    // basic borrow cases
    issue(4'b0011, 4'b0101, 1'b0, {4'b1110, 1'b1, 1'b0}, 1'b0);
    issue(4'b0000, 4'b0000, 1'b1, {4'b1111, 1'b1, 1'b0}, 1'b0);
    // signed overflow
    issue(4'b0111, 4'b1000, 1'b0, {4'b1111, 1'b1, 1'b1}, 1'b0);
    issue(4'b1000, 4'b0001, 1'b0, {4'b0111, 1'b0, 1'b1}, 1'b0);
    issue(4'b1111, 4'b1111, 1'b1, {4'b1111, 1'b1, 1'b0}, 1'b0);
    wait_ready();
    idle_cycles(2);

    // interference while busy
    done_before = done_seen;
    issue(4'b0101, 4'b0011, 1'b0, {4'b0010, 1'b0, 1'b0}, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'b1111;
    bus.b = 4'b1111;
    bus.b_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready();
    idle_cycles(4);
    check("single done under interference", done_seen - done_before, 32'd1);
    check("d held after interference", {28'd0, bus.d}, 32'h2);

    // back-to-back with start held high
    issue(4'b0101, 4'b0011, 1'b0, {4'b0010, 1'b0, 1'b0}, 1'b1);
    issue(4'b0011, 4'b0101, 1'b0, {4'b1110, 1'b1, 1'b0}, 1'b1);
    issue(4'b0101, 4'b0011, 1'b0, {4'b0010, 1'b0, 1'b0}, 1'b1);
    issue(4'b0011, 4'b0101, 1'b0, {4'b1110, 1'b1, 1'b0}, 1'b0);
    wait_ready();
    idle_cycles(2);

    // asynchronous reset in cycle 2 of RUN
    done_before = done_seen;
    bus.start = 1'b1;
    bus.a = 4'b0111;
    bus.b = 4'b0001;
    bus.b_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    check("no done across reset", done_seen - done_before, 32'd0);
    issue(4'b1001, 4'b0001, 1'b0, {4'b1000, 1'b0, 1'b0}, 1'b0);

    // drain
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard drained", exp_q.size(), 32'd0);
    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes D = A − B − bin, one bit per clock, LSB first, using full-subtractor logic: diff = a^b^borrow, borrow_next = (~a&b) | (~(a^b)&borrow).
- This is the subtract-direction counterpart of the team's decoder-based ripple adder. It is intended for area-constrained datapaths where a WIDTH-bit ripple chain is too large.
- A start/done handshake frames each operation. The result is held until the next completion.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk edge.
- a  input  WIDTH  minuend; sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- b_in  input  1  borrow-in; sampled only on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- d  output  WIDTH  difference, held until the next completion.
- b_out  output  1  borrow-out from the MSB. Equals 1 iff unsigned a < b + b_in.
- v  output  1  signed overflow, held with d.

Behaviour:
- Reset (rst_n=0, asynchronous, regardless of clk):
  - state=IDLE; busy=0, done=0, d=0, b_out=0, v=0.
  - Shift registers, borrow and counter all cleared.
  - Release is synchronous to the next edge.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge E0 → RUN.
  - At E0: latch a, b; borrow←b_in; cnt←0.
  - start=0 → stay in IDLE.
- RUN (busy=1):
  - Each edge computes one difference bit from the LSBs of the A/B shift registers and the borrow.
  - The bit shifts into the MSB of the result shift register. A and B shift right, borrow updates, cnt increments.
  - On the edge where cnt==WIDTH−1 (edge E_WIDTH), in addition:
    - state→DONE.
    - d←final result word; b_out←final borrow.
    - v←(a_msb ^ b_msb) & (a_msb ^ d_msb), using the latched operand MSBs.
  - start is ignored in RUN; no re-latch, no error.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - start=1 at this edge is accepted like in IDLE: → RUN, latch new operands, done→0. This gives back-to-back operation.
  - Otherwise → IDLE.
- Latency: start accepted at E0 → busy visible after E0 → done visible after E_WIDTH, i.e. WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+1 cycles when start is held high.
- d, b_out, v change only at completion edges and at reset. They stay stable through IDLE and through a subsequent RUN.
- Input changes on a, b, b_in after the accepting edge have no effect on the running operation.
- Reset asserted mid-RUN:
  - Aborts immediately; all outputs return to reset values; no done pulse.
  - The previously held result is lost (d=0).
- Arithmetic is modulo 2^WIDTH, with no saturation.
- b_out and v are independent: unsigned borrow vs signed overflow.

Test Plan:
- WIDTH=4. a=0101, b=0011, b_in=0, start pulse → done exactly 4 cycles after the accepting edge. Result: d=0010, b_out=0, v=0. busy high for cycles 1–4 after acceptance.
- a=0011, b=0101, b_in=0 → d=1110, b_out=1, v=0. Then a=0000, b=0000, b_in=1 → d=1111, b_out=1, v=0.
- Signed overflow, a=0111, b=1000, b_in=0 → d=1111, b_out=1, v=1. Then a=1000, b=0001 → d=0111, b_out=0, v=1.
- Interference while busy: start pulse during RUN, with a/b changed to 1111/1111 mid-operation. The original result (from a=0101, b=0011) is still 0010, and only one done pulse occurs. After done and return to IDLE, d stays at 0010.
- start held high continuously with alternating operands. done pulses every 5 cycles, busy low only during DONE cycles, and each d matches its operand pair.
- rst_n driven low asynchronously between edges at cycle 2 of RUN. Outputs go to 0 immediately, with no done pulse. After release, a fresh operation 1001−0001 → d=1000, b_out=0, v=0.
